// File: rtl/payload_tx_framer.sv
// Drains LEN bytes from the payload FIFO and emits them toward the UART TX as
// a frame: SOF, STATUS, LEN_HI, LEN_LO, payload..., XOR checksum.
module payload_tx_framer #(
    parameter int          MAX_LEN  = 256,
    parameter logic [7:0]  SOF_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] len,
    input  logic [7:0] status,
    output logic       busy,
    output logic       done,
    output logic       len_err,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_rd_data,
    input  logic       fifo_empty,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready
);

    localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

    typedef enum logic [3:0] {
        S_IDLE, S_SOF, S_STAT, S_LENH, S_LENL,
        S_FETCH, S_WAIT, S_DATA, S_CSUM, S_FIN
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] status_reg, status_next;
    logic [8:0] eff_len_reg, eff_len_next;
    logic [8:0] remaining_reg, remaining_next;
    logic [7:0] csum_reg, csum_next;
    logic [7:0] data_reg, data_next;
    logic       len_err_reg, len_err_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            status_reg    <= 8'h00;
            eff_len_reg   <= 9'd0;
            remaining_reg <= 9'd0;
            csum_reg      <= 8'h00;
            data_reg      <= 8'h00;
            len_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            status_reg    <= status_next;
            eff_len_reg   <= eff_len_next;
            remaining_reg <= remaining_next;
            csum_reg      <= csum_next;
            data_reg      <= data_next;
            len_err_reg   <= len_err_next;
        end
    end

    // Outputs are decoded from the registered state, so tx_data cannot move
    // while a byte is waiting for tx_ready.
    always_comb begin
        state_next     = state_reg;
        status_next    = status_reg;
        eff_len_next   = eff_len_reg;
        remaining_next = remaining_reg;
        csum_next      = csum_reg;
        data_next      = data_reg;
        len_err_next   = len_err_reg;
        busy           = 1'b0;
        done           = 1'b0;
        fifo_rd_en     = 1'b0;
        tx_valid       = 1'b0;
        tx_data        = 8'h00;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    status_next  = status;
                    eff_len_next = (len > MAX_LEN_W) ? MAX_LEN_W : len;
                    len_err_next = (len > MAX_LEN_W);
                    csum_next    = 8'h00;
                    state_next   = S_SOF;
                end
            end
            S_SOF: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = SOF_BYTE;
                if (tx_ready) state_next = S_STAT;
            end
            S_STAT: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = status_reg;
                if (tx_ready) begin
                    csum_next  = csum_reg ^ status_reg;
                    state_next = S_LENH;
                end
            end
            S_LENH: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = {7'b0, eff_len_reg[8]};
                if (tx_ready) begin
                    csum_next  = csum_reg ^ {7'b0, eff_len_reg[8]};
                    state_next = S_LENL;
                end
            end
            S_LENL: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = eff_len_reg[7:0];
                if (tx_ready) begin
                    csum_next      = csum_reg ^ eff_len_reg[7:0];
                    remaining_next = eff_len_reg;
                    state_next     = (eff_len_reg != 9'd0) ? S_FETCH : S_CSUM;
                end
            end
            S_FETCH: begin
                busy = 1'b1;
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // FIFO read data lands one cycle after the pop.
                busy       = 1'b1;
                data_next  = fifo_rd_data;
                state_next = S_DATA;
            end
            S_DATA: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = data_reg;
                if (tx_ready) begin
                    csum_next      = csum_reg ^ data_reg;
                    remaining_next = remaining_reg - 9'd1;
                    state_next     = (remaining_reg != 9'd1) ? S_FETCH : S_CSUM;
                end
            end
            S_CSUM: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = csum_reg;
                if (tx_ready) state_next = S_FIN;
            end
            S_FIN: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign len_err = len_err_reg;

endmodule

// File: tb/tb_payload_tx_framer.sv
// Directed and randomized frames against a queue-based frame model with a
// registered-read FIFO model feeding the framer.
module tb_payload_tx_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [8:0] len = 9'd0;
    logic [7:0] status = 8'h00;
    logic       busy, done, len_err, fifo_rd_en, tx_valid;
    logic [7:0] tx_data;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       tx_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int ready_pct = 100;
    int pop_cnt = 0;
    int done_cnt = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pay_q[$];

    logic [7:0] held_data;
    bit         held = 1'b0;

    payload_tx_framer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len),
        .status       (status),
        .busy         (busy),
        .done         (done),
        .len_err      (len_err),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Registered-read FIFO model.
    always @(posedge clk) begin
        if (rst && fifo_rd_en) begin
            vectors++;
            assert (fifo_q.size() != 0) else begin
                miscompares++;
                $error("FAIL pop_when_empty: observed fifo_rd_en=1 with empty FIFO, expected no pop");
            end
            if (fifo_q.size() != 0) fifo_rd_data <= fifo_q.pop_front();
            pop_cnt++;
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    always @(posedge clk) begin
        #1;
        tx_ready = ($urandom_range(0, 99) < ready_pct);
    end

    // Handshake recorder, hold-stability and done/busy checks.
    always @(negedge clk) begin
        if (!rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                vectors++;
                assert (tx_valid === 1'b1 && tx_data === held_data) else begin
                    miscompares++;
                    $error("FAIL hold_stable: observed valid=%b data=%h expected valid=1 data=%h",
                           tx_valid, tx_data, held_data);
                end
            end
            held      = tx_valid && !tx_ready;
            held_data = tx_data;
            if (tx_valid && tx_ready) obs_q.push_back(tx_data);
            if (done) begin
                done_cnt++;
                vectors++;
                assert (busy === 1'b0) else begin
                    miscompares++;
                    $error("FAIL busy_at_done: observed %b expected 0", busy);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_payload();
        foreach (pay_q[i]) fifo_q.push_back(pay_q[i]);
        if (fifo_q.size() != 0) fifo_empty = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] st, input logic [8:0] ln,
                             input int push_delay, input int pct, input bit poke_start);
        logic [8:0] eff;
        logic [7:0] cs;
        int t;
        eff = (ln > 9'd256) ? 9'd256 : ln;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(st);
        exp_q.push_back({7'b0, eff[8]});
        exp_q.push_back(eff[7:0]);
        cs = st ^ {7'b0, eff[8]} ^ eff[7:0];
        for (int i = 0; i < int'(eff); i++) begin
            exp_q.push_back(pay_q[i]);
            cs ^= pay_q[i];
        end
        exp_q.push_back(cs);

        obs_q.delete();
        pop_cnt   = 0;
        done_cnt  = 0;
        ready_pct = pct;
        if (push_delay == 0) push_payload();

        @(posedge clk); #1;
        status = st;
        len    = ln;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        len    = 9'($urandom);
        status = 8'($urandom);
        @(negedge clk);
        check("busy_after_start", {31'b0, busy}, 32'd1);

        if (poke_start) begin
            @(posedge clk); #1;
            start = 1'b1;
            len   = 9'd0;
            @(posedge clk); #1;
            start = 1'b0;
        end

        if (push_delay > 0) begin
            repeat (push_delay) @(negedge clk);
            check("stall_tx_valid", {31'b0, tx_valid}, 32'd0);
            check("stall_rd_en", {31'b0, fifo_rd_en}, 32'd0);
            check("stall_busy", {31'b0, busy}, 32'd1);
            push_payload();
        end

        t = 0;
        while (done_cnt == 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("done_within_budget", {31'b0, (t < 20000)}, 32'd1);
        repeat (3) @(negedge clk);

        check("frame_size", obs_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) check($sformatf("byte[%0d]", i), {24'b0, obs_q[i]}, {24'b0, exp_q[i]});
        end
        check("done_pulses", done_cnt, 32'd1);
        check("pop_count", pop_cnt, {23'b0, eff});
        check("fifo_left", fifo_q.size(), 32'd0);
        check("len_err", {31'b0, len_err}, {31'b0, (ln > 9'd256)});
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_tx_valid", {31'b0, tx_valid}, 32'd0);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_len_err", {31'b0, len_err}, 32'd0);
        check("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'b0, tx_data}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic three-byte frame.
        pay_q = '{8'h11, 8'h22, 8'h33};
        run_frame(8'h00, 9'd3, 0, 100, 1'b0);

        // Empty payload.
        pay_q.delete();
        run_frame(8'h5A, 9'd0, 0, 100, 1'b0);

        // Oversized request clamps to 256.
        pay_q.delete();
        for (int i = 0; i < 256; i++) pay_q.push_back(8'(i));
        run_frame(8'h00, 9'd300, 0, 100, 1'b0);

        // FIFO empty at first, filled 20 cycles later.
        pay_q = '{8'h3C, 8'hC3};
        run_frame(8'h81, 9'd2, 20, 100, 1'b0);

        // Sluggish transmitter, same bytes as the first frame.
        pay_q = '{8'h11, 8'h22, 8'h33};
        run_frame(8'h00, 9'd3, 0, 30, 1'b0);

        // Start pulsed mid-frame must be ignored.
        pay_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
        run_frame(8'h77, 9'd5, 0, 100, 1'b1);

        // Randomized frames.
        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(0, 24);
            pay_q.delete();
            for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
            run_frame(8'($urandom), 9'(n), 0, $urandom_range(40, 100), 1'b0);
        end

        // Reset during the payload of a len=4 frame.
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        obs_q.delete();
        done_cnt  = 0;
        ready_pct = 100;
        push_payload();
        @(posedge clk); #1;
        status = 8'h44;
        len    = 9'd4;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        t = 0;
        while (obs_q.size() < 5 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("reached_payload", {31'b0, (t < 200)}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        check("abort_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("abort_tx_data", {24'b0, tx_data}, 32'd0);
        repeat (3) @(negedge clk);
        fifo_q.delete();
        fifo_empty = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt, 32'd0);

        pay_q = '{8'h9E};
        run_frame(8'h12, 9'd1, 0, 100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
